tick_gen: RTL and testbench

- Producer side of the single-cycle `pulse` strobe consumed by the game's decade/seconds counters.
- Divides the system clock into a programmable-period strobe, one clock wide.
- Start/pause/resume/clear control lets the game FSM freeze and restart timing between rounds.
- Sits between the board clock and every pulse-driven counter.

---
 rtl/tick_gen_pkg.sv | 25 ++
 rtl/tick_gen_if.sv | 39 +++
 rtl/tick_gen_prescaler.sv | 64 ++++++
 rtl/tick_gen.sv | 134 +++++++++++++
 tb/tb_tick_gen.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared state encoding, default period and period clamp for tick_gen
package tick_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int unsigned DEF_CLK_HZ  = 50_000_000;
    localparam int unsigned DEF_TICK_HZ = 10;
    localparam int unsigned DEF_PERIOD  = DEF_CLK_HZ / DEF_TICK_HZ;

    // Reset-time period in clocks for a given clock/strobe rate pair.
    function automatic int unsigned default_period(input int unsigned clk_hz,
                                                   input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // A period of zero clocks is meaningless; treat it as one clock.
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/tick_gen_if.sv
// rtl/tick_gen_if.sv - control/strobe bundle between tick_gen and its controller
// Signals: start, stop, clear, period_ld, period_in (controller -> tick_gen);
//          pulse, running, tick_cnt (tick_gen -> consumers).
// Optional macro TICK_GEN_BURST_EN adds burst_len (in) and done (out).
interface tick_gen_if #(
    parameter int CNT_W  = 26,
    parameter int TCNT_W = 8
);
    logic              start;
    logic              stop;
    logic              clear;
    logic              period_ld;
    logic [CNT_W-1:0]  period_in;
    logic              pulse;
    logic              running;
    logic [TCNT_W-1:0] tick_cnt;
`ifdef TICK_GEN_BURST_EN
    logic [TCNT_W-1:0] burst_len;
    logic              done;

    modport master (
        output start, stop, clear, period_ld, period_in, burst_len,
        input  pulse, running, tick_cnt, done
    );
    modport slave (
        input  start, stop, clear, period_ld, period_in, burst_len,
        output pulse, running, tick_cnt, done
    );
`else
    modport master (
        output start, stop, clear, period_ld, period_in,
        input  pulse, running, tick_cnt
    );
    modport slave (
        input  start, stop, clear, period_ld, period_in,
        output pulse, running, tick_cnt
    );
`endif
endinterface

// File: rtl/tick_gen_prescaler.sv
// rtl/tick_gen_prescaler.sv - period counter with pending-period register and wrap detect
// Ports: i_clk, i_rst (async active-low), i_count_en (advance this clock),
//        i_cnt_clr (force count to zero), i_apply_idle (controller idle, pending
//        period may be applied), i_period_ld/i_period_in (load pending period),
//        o_wrap (terminal count reached on an advancing clock).
module tick_prescaler
    import tick_gen_pkg::*;
#(
    parameter int               CNT_W      = 26,
    parameter logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_count_en,
    input  logic             i_cnt_clr,
    input  logic             i_apply_idle,
    input  logic             i_period_ld,
    input  logic [CNT_W-1:0] i_period_in,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period_q;
    logic [CNT_W-1:0] r_pend_q;
    logic             r_pend_v;

    logic             w_term;
    logic             w_apply;
    logic [CNT_W-1:0] w_ld_val;

    assign w_term   = (r_cnt == (r_period_q - CNT_W'(1)));
    assign o_wrap   = i_count_en && w_term;
    // Pending period only takes effect at a period boundary or while idle,
    // so the running count can never overshoot the active period.
    assign w_apply  = r_pend_v && (o_wrap || i_apply_idle);
    assign w_ld_val = CNT_W'(clamp_period(32'(i_period_in)));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt      <= '0;
            r_period_q <= RST_PERIOD;
            r_pend_q   <= RST_PERIOD;
            r_pend_v   <= 1'b0;
        end else begin
            if (i_cnt_clr || o_wrap) begin
                r_cnt <= '0;
            end else if (i_count_en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Apply uses the old pending value; a same-cycle load becomes the next pending one.
            if (w_apply) begin
                r_period_q <= r_pend_q;
            end
            if (i_period_ld) begin
                r_pend_q <= w_ld_val;
                r_pend_v <= 1'b1;
            end else if (w_apply) begin
                r_pend_v <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - programmable-period one-clock strobe generator with start/pause/resume/clear
// Ports: i_clk (rising edge), i_rst (async active-low), bus (tick_gen_if.slave:
//        start, stop, clear, period_ld, period_in in; pulse, running, tick_cnt out).
// Optional macro TICK_GEN_BURST_EN: burst_len in, done out; stops after burst_len pulses.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
    parameter int unsigned TICK_HZ = DEF_TICK_HZ,
    parameter int          CNT_W   = 26,
    parameter int          TCNT_W  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    tick_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(default_period(CLK_HZ, TICK_HZ));

    state_t            r_state;
    state_t            w_next;
    logic              w_idle;
    logic              w_count_en;
    logic              w_wrap;
    logic              w_final;
    logic              r_pulse;
    logic              r_running;
    logic [TCNT_W-1:0] r_tick_cnt;

    assign w_idle     = (r_state == ST_IDLE);
    // stop and clear both win over the count, so a terminal-count cycle with either emits nothing.
    assign w_count_en = (r_state == ST_RUN) && !bus.stop && !bus.clear;

    tick_prescaler #(
        .CNT_W      (CNT_W),
        .RST_PERIOD (RST_PERIOD)
    ) u_prescaler (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_count_en   (w_count_en),
        .i_cnt_clr    (bus.clear || w_idle),
        .i_apply_idle (w_idle),
        .i_period_ld  (bus.period_ld),
        .i_period_in  (bus.period_in),
        .o_wrap       (w_wrap)
    );

`ifdef TICK_GEN_BURST_EN
    logic [TCNT_W-1:0] r_blen;
    logic [TCNT_W-1:0] r_bcnt;
    logic              r_done;

    // Final pulse of a burst: r_bcnt counts pulses already emitted in this burst.
    assign w_final = w_wrap && (r_blen != '0) && (r_bcnt == (r_blen - TCNT_W'(1)));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_blen <= '0;
            r_bcnt <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_final;
            if (w_idle && (w_next == ST_RUN)) begin
                r_blen <= bus.burst_len;
                r_bcnt <= '0;
            end else if (w_wrap) begin
                r_bcnt <= r_bcnt + TCNT_W'(1);
            end
        end
    end

    assign bus.done = r_done;
`else
    assign w_final = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    w_next = ST_PAUSE;
                end else if (w_final) begin
                    w_next = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (!bus.stop && bus.start) begin
                    w_next = ST_RUN;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (bus.clear) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pulse    <= 1'b0;
            r_running  <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_pulse   <= w_wrap;
            r_running <= (w_next == ST_RUN);
            if (bus.clear) begin
                r_tick_cnt <= '0;
            end else if (w_wrap) begin
                r_tick_cnt <= r_tick_cnt + TCNT_W'(1);
            end
        end
    end

    assign bus.pulse    = r_pulse;
    assign bus.running  = r_running;
    assign bus.tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - self-checking bench for tick_gen against a countdown reference model
module tb_tick_gen;

    localparam int CNT_W   = 26;
    localparam int TCNT_W  = 8;
    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tick_gen_if #(.CNT_W(CNT_W), .TCNT_W(TCNT_W)) bus ();

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .CNT_W   (CNT_W),
        .TCNT_W  (TCNT_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus.slave)
    );

    logic dut_done;
`ifdef TICK_GEN_BURST_EN
    assign dut_done = bus.done;
`else
    assign dut_done = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: clocks remaining until the next strobe, counted down.
    mstate_t m_st;
    int      m_left, m_period, m_pend, m_tick, m_blen, m_bcnt;
    bit      m_pend_v, m_pulse, m_run, m_done;

    function automatic void model_reset();
        m_st     = M_IDLE;
        m_period = CLK_HZ / TICK_HZ;
        m_pend   = CLK_HZ / TICK_HZ;
        m_pend_v = 0;
        m_left   = 0;
        m_tick   = 0;
        m_blen   = 0;
        m_bcnt   = 0;
        m_pulse  = 0;
        m_run    = 0;
        m_done   = 0;
    endfunction

    function automatic void model_step(bit s, bit p, bit c, bit ld, int pin, int blen);
        mstate_t nst;
        nst     = m_st;
        m_pulse = 0;
        m_done  = 0;
        if (m_st == M_IDLE && m_pend_v) begin
            m_period = m_pend;
            m_pend_v = 0;
        end
        if (c) begin
            nst    = M_IDLE;
            m_tick = 0;
        end else if (m_st == M_IDLE) begin
            if (s) begin
                nst    = M_RUN;
                m_left = m_period;
                m_blen = blen;
                m_bcnt = 0;
            end
        end else if (m_st == M_RUN) begin
            if (p) begin
                nst = M_PAUSE;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_pulse = 1;
                    m_tick  = (m_tick + 1) % (1 << TCNT_W);
                    if (m_pend_v) begin
                        m_period = m_pend;
                        m_pend_v = 0;
                    end
                    m_left = m_period;
                    m_bcnt++;
                    if (m_blen != 0 && m_bcnt == m_blen) begin
                        nst    = M_IDLE;
                        m_done = 1;
                    end
                end
            end
        end else begin
            if (!p && s) nst = M_RUN;
        end
        if (ld) begin
            m_pend   = (pin == 0) ? 1 : pin;
            m_pend_v = 1;
        end
        m_st  = nst;
        m_run = (nst == M_RUN);
    endfunction

    function automatic logic [TCNT_W+2:0] dut_vec();
        return {bus.pulse, bus.running, dut_done, bus.tick_cnt};
    endfunction

    function automatic logic [TCNT_W+2:0] model_vec();
        return {m_pulse, m_run, m_done, TCNT_W'(m_tick)};
    endfunction

    task automatic set_in(input bit s, input bit p, input bit c, input bit ld, input int pin);
        bus.start     = s;
        bus.stop      = p;
        bus.clear     = c;
        bus.period_ld = ld;
        bus.period_in = CNT_W'(pin);
    endtask

    task automatic step();
        int bl;
        @(posedge clk);
`ifdef TICK_GEN_BURST_EN
        bl = int'(bus.burst_len);
`else
        bl = 0;
`endif
        model_step(bus.start, bus.stop, bus.clear, bus.period_ld, int'(bus.period_in), bl);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0);
        #1;
        n_total++;
        if (dut_vec() !== '0) $display("FAIL reset_outputs: got %h want 0", dut_vec());
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int e = 1; e <= 3; e++) begin
            step();
            n_total++;
            if (dut_vec() !== '0) $display("FAIL reset_idle e%0d: got %h want 0", e, dut_vec());
            else n_pass++;
        end
    endtask

    task automatic test_latency();
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            set_in(e == 5, 0, 0, 0, 0);
            step();
            n_total++;
            if (dut_vec() !== model_vec()) $display("FAIL latency_model e%0d: got %h want %h", e, dut_vec(), model_vec());
            else n_pass++;
            n_total++;
            if (bus.pulse !== (e == 15 || e == 25 || e == 35)) $display("FAIL latency_pulse e%0d: got %b", e, bus.pulse);
            else n_pass++;
            n_total++;
            if (bus.running !== (e >= 5)) $display("FAIL latency_running e%0d: got %b", e, bus.running);
            else n_pass++;
        end
        n_total++;
        if (bus.tick_cnt !== 8'd3) $display("FAIL latency_tick_cnt: got %0d want 3", bus.tick_cnt);
        else n_pass++;
    endtask

    task automatic test_pause_resume();
        do_reset();
        for (int e = 1; e <= 45; e++) begin
            set_in(e == 1 || e == 29, e == 8, 0, 0, 0);
            step();
            n_total++;
            if (dut_vec() !== model_vec()) $display("FAIL pause_model e%0d: got %h want %h", e, dut_vec(), model_vec());
            else n_pass++;
            n_total++;
            if (bus.pulse !== (e == 33 || e == 43)) $display("FAIL pause_pulse e%0d: got %b", e, bus.pulse);
            else n_pass++;
            n_total++;
            if (bus.running !== ((e < 8) || (e >= 29))) $display("FAIL pause_running e%0d: got %b", e, bus.running);
            else n_pass++;
        end
    endtask

    task automatic test_period_load();
        do_reset();
        for (int e = 1; e <= 25; e++) begin
            set_in(e == 1, 0, 0, e == 5, 4);
            step();
            n_total++;
            if (dut_vec() !== model_vec()) $display("FAIL pld_model e%0d: got %h want %h", e, dut_vec(), model_vec());
            else n_pass++;
            n_total++;
            if (bus.pulse !== (e == 11 || e == 15 || e == 19 || e == 23)) $display("FAIL pld_pulse e%0d: got %b", e, bus.pulse);
            else n_pass++;
        end
    endtask

    task automatic test_period_one();
        int exp_tick;
        do_reset();
        for (int e = 1; e <= 262; e++) begin
            set_in(e == 3, 0, 0, e == 1, 0);
            step();
            exp_tick = (e >= 4) ? (e - 3) % 256 : 0;
            n_total++;
            if (dut_vec() !== model_vec()) $display("FAIL p1_model e%0d: got %h want %h", e, dut_vec(), model_vec());
            else n_pass++;
            n_total++;
            if (bus.pulse !== (e >= 4) || bus.tick_cnt !== 8'(exp_tick))
                $display("FAIL p1_pulse_tick e%0d: got %b/%0d want %b/%0d", e, bus.pulse, bus.tick_cnt, e >= 4, exp_tick);
            else n_pass++;
        end
    endtask

    task automatic test_clear_stop();
        int exp_tick;
        do_reset();
        for (int e = 1; e <= 28; e++) begin
            set_in(e == 1 || e == 16, e == 14, e == 14, 0, 0);
            step();
            exp_tick = ((e >= 11 && e < 14) || e >= 26) ? 1 : 0;
            n_total++;
            if (dut_vec() !== model_vec()) $display("FAIL clr_model e%0d: got %h want %h", e, dut_vec(), model_vec());
            else n_pass++;
            n_total++;
            if (bus.pulse !== (e == 11 || e == 26) || bus.tick_cnt !== 8'(exp_tick) ||
                bus.running !== ((e < 14) || (e >= 16)))
                $display("FAIL clr_outputs e%0d: got p%b r%b t%0d want t%0d", e, bus.pulse, bus.running, bus.tick_cnt, exp_tick);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            set_in(e == 1, e == 26, 0, 0, 0);
            step();
        end
        n_total++;
        if (bus.tick_cnt !== 8'd2 || bus.running !== 1'b0) $display("FAIL arst_pre: got t%0d r%b want t2 r0", bus.tick_cnt, bus.running);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (dut_vec() !== '0) $display("FAIL arst_async: got %h want 0", dut_vec());
        else n_pass++;
        for (int e = 1; e <= 3; e++) begin
            set_in(1, 0, 0, 0, 0);
            @(posedge clk);
            #1;
            n_total++;
            if (dut_vec() !== '0) $display("FAIL arst_hold e%0d: got %h want 0", e, dut_vec());
            else n_pass++;
        end
        do_reset();
    endtask

`ifdef TICK_GEN_BURST_EN
    task automatic test_burst();
        int npulse = 0;
        do_reset();
        bus.burst_len = 8'd3;
        for (int e = 1; e <= 45; e++) begin
            set_in(e == 1, 0, 0, 0, 0);
            step();
            if (bus.pulse === 1'b1) npulse++;
            n_total++;
            if (dut_vec() !== model_vec()) $display("FAIL burst_model e%0d: got %h want %h", e, dut_vec(), model_vec());
            else n_pass++;
            n_total++;
            if (bus.done !== (e == 31) || bus.running !== (e >= 1 && e < 31))
                $display("FAIL burst_done e%0d: got d%b r%b", e, bus.done, bus.running);
            else n_pass++;
        end
        n_total++;
        if (npulse != 3) $display("FAIL burst_count: got %0d want 3", npulse);
        else n_pass++;
        bus.burst_len = '0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int e = 1; e <= 1500; e++) begin
            set_in($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2,
                   $urandom_range(0, 99) < 8, int'($urandom_range(0, 7)));
`ifdef TICK_GEN_BURST_EN
            bus.burst_len = 8'($urandom_range(0, 4));
`endif
            step();
            n_total++;
            if (dut_vec() !== model_vec()) $display("FAIL random e%0d: got %h want %h", e, dut_vec(), model_vec());
            else n_pass++;
        end
    endtask

    initial begin
`ifdef TICK_GEN_BURST_EN
        bus.burst_len = '0;
`endif
        test_reset();
        test_latency();
        test_pause_resume();
        test_period_load();
        test_period_one();
        test_clear_stop();
        test_async_reset();
`ifdef TICK_GEN_BURST_EN
        test_burst();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
